// File: rtl/alu_seq_if.sv
// alu_seq_if: command/result bundle between the EX-stage control and alu_seq.
// Carries prod_hi_o only when ALU_SEQ_MUL_HI_EN is defined.
interface alu_seq_if #(parameter int WIDTH = 32);
   logic             start_i;
   logic [3:0]       alu_ctrl_i;
   logic [WIDTH-1:0] src1_i;
   logic [WIDTH-1:0] src2_i;
   logic [WIDTH-1:0] result_o;
   logic             zero_o;
   logic             busy_o;
   logic             done_o;
   logic             err_o;
`ifdef ALU_SEQ_MUL_HI_EN
   logic [WIDTH-1:0] prod_hi_o;
   modport master (output start_i, alu_ctrl_i, src1_i, src2_i,
                   input result_o, zero_o, busy_o, done_o, err_o, prod_hi_o);
   modport slave (input start_i, alu_ctrl_i, src1_i, src2_i,
                  output result_o, zero_o, busy_o, done_o, err_o, prod_hi_o);
`else
   modport master (output start_i, alu_ctrl_i, src1_i, src2_i,
                   input result_o, zero_o, busy_o, done_o, err_o);
   modport slave (input start_i, alu_ctrl_i, src1_i, src2_i,
                  output result_o, zero_o, busy_o, done_o, err_o);
`endif
endinterface

// File: rtl/alu_seq.sv
// alu_seq: EX-stage ALU, 1-cycle AND/OR/ADD/SUB/SLT and WIDTH-cycle shift-add MUL.
// Optional ALU_SEQ_MUL_HI_EN widens the accumulator and drives prod_hi_o.
module alu_seq #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input logic      clk_i,
   input logic      rst_i,
   alu_seq_if.slave bus
);
`ifdef ALU_SEQ_MUL_HI_EN
   localparam int ACC_W = 2 * WIDTH;
`else
   localparam int ACC_W = WIDTH;
`endif
   localparam logic [3:0] OP_AND = 4'b0000;
   localparam logic [3:0] OP_OR  = 4'b0001;
   localparam logic [3:0] OP_ADD = 4'b0010;
   localparam logic [3:0] OP_SUB = 4'b0110;
   localparam logic [3:0] OP_SLT = 4'b0111;
   localparam logic [3:0] OP_MUL = 4'b1000;

   typedef enum logic {S_IDLE, S_MUL} state_t;

   state_t           r_state, w_state_nxt;
   logic [ACC_W-1:0] r_mcand, r_acc, w_acc_nxt;
   logic [WIDTH-1:0] r_mplier, r_result, w_op_res;
   logic [CNT_W-1:0] r_cnt;
   logic             r_zero, r_done, r_err;
   logic             w_accept, w_is_mul, w_mul_last;
`ifdef ALU_SEQ_MUL_HI_EN
   logic [WIDTH-1:0] r_prod_hi;
   assign bus.prod_hi_o = r_prod_hi;
`endif

   assign bus.result_o = r_result;
   assign bus.zero_o   = r_zero;
   assign bus.busy_o   = (r_state == S_MUL);
   assign bus.done_o   = r_done;
   assign bus.err_o    = r_err;

   always_comb begin
      w_accept    = (r_state == S_IDLE) && bus.start_i;
      w_is_mul    = (bus.alu_ctrl_i == OP_MUL);
      w_mul_last  = (r_state == S_MUL) && (r_cnt == '0);
      w_acc_nxt   = r_mplier[0] ? r_acc + r_mcand : r_acc;
      // Illegal codes fall through to zero; err_o is derived from the same decode.
      w_op_res    = (bus.alu_ctrl_i == OP_AND) ? bus.src1_i & bus.src2_i :
                    (bus.alu_ctrl_i == OP_OR)  ? bus.src1_i | bus.src2_i :
                    (bus.alu_ctrl_i == OP_ADD) ? bus.src1_i + bus.src2_i :
                    (bus.alu_ctrl_i == OP_SUB) ? bus.src1_i - bus.src2_i :
                    (bus.alu_ctrl_i == OP_SLT) ?
                       {{(WIDTH-1){1'b0}}, $signed(bus.src1_i) < $signed(bus.src2_i)} : '0;
      w_state_nxt = (w_accept && w_is_mul) ? S_MUL : w_mul_last ? S_IDLE : r_state;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         r_mcand  <= '0;
         r_mplier <= '0;
         r_acc    <= '0;
         r_cnt    <= '0;
         r_result <= '0;
         r_zero   <= 1'b1;
         r_done   <= 1'b0;
         r_err    <= 1'b0;
`ifdef ALU_SEQ_MUL_HI_EN
         r_prod_hi <= '0;
`endif
      end else begin
         r_done <= 1'b0;
         if (w_accept && w_is_mul) begin
            r_mcand  <= ACC_W'(bus.src1_i);
            r_mplier <= bus.src2_i;
            r_acc    <= '0;
            r_cnt    <= CNT_W'(WIDTH - 1);
            r_err    <= 1'b0;
         end else if (w_accept) begin
            r_result <= w_op_res;
            r_zero   <= (w_op_res == '0);
            r_done   <= 1'b1;
            r_err    <= !(bus.alu_ctrl_i inside {OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT});
`ifdef ALU_SEQ_MUL_HI_EN
            r_prod_hi <= '0;
`endif
         end else if (r_state == S_MUL) begin
            r_acc    <= w_acc_nxt;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt - 1'b1;
            if (w_mul_last) begin
               r_result <= w_acc_nxt[WIDTH-1:0];
               r_zero   <= (w_acc_nxt[WIDTH-1:0] == '0);
               r_done   <= 1'b1;
`ifdef ALU_SEQ_MUL_HI_EN
               r_prod_hi <= w_acc_nxt[ACC_W-1:WIDTH];
`endif
            end
         end
      end
   end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed vector table for single-cycle ops plus MUL/reset sequences.
module tb_alu_seq;
   logic clk_i = 1'b0;
   logic rst_i = 1'b0;
   int   n_cmp = 0;
   int   n_bad = 0;

   alu_seq_if #(.WIDTH(32)) bus ();
   alu_seq #(.WIDTH(32), .CNT_W(6)) dut (.clk_i(clk_i), .rst_i(rst_i), .bus(bus));

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic        err;
   } vec_t;
   vec_t vecs[12];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic apply(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] res, input logic err);
      bus.start_i = 1'b1; bus.alu_ctrl_i = op; bus.src1_i = a; bus.src2_i = b;
      @(posedge clk_i); #1;
      chk({tag, " result"}, 64'(bus.result_o), 64'(res));
      chk({tag, " zero"}, 64'(bus.zero_o), 64'(res == 32'd0));
      chk({tag, " done"}, 64'(bus.done_o), 64'd1);
      chk({tag, " err"}, 64'(bus.err_o), 64'(err));
      chk({tag, " busy"}, 64'(bus.busy_o), 64'd0);
`ifdef ALU_SEQ_MUL_HI_EN
      chk({tag, " prod_hi"}, 64'(bus.prod_hi_o), 64'd0);
`endif
   endtask

   task automatic mul_run(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] res, input logic [31:0] hi);
      int bad_busy = 0;
      int n;
      bus.start_i = 1'b1; bus.alu_ctrl_i = 4'b1000; bus.src1_i = a; bus.src2_i = b;
      @(posedge clk_i); #1;
      chk({tag, " busy after accept"}, 64'(bus.busy_o), 64'd1);
      chk({tag, " no done at accept"}, 64'(bus.done_o), 64'd0);
      for (n = 1; n <= 64; n++) begin
         bus.start_i = (n == 5);
         bus.alu_ctrl_i = 4'b0010; bus.src1_i = 32'd1; bus.src2_i = 32'd1;
         @(posedge clk_i); #1;
         bus.start_i = 1'b0;
         if (bus.done_o) break;
         if (!bus.busy_o) bad_busy++;
      end
      chk({tag, " done latency"}, 64'(n), 64'd32);
      chk({tag, " busy gaps"}, 64'(bad_busy), 64'd0);
      chk({tag, " result"}, 64'(bus.result_o), 64'(res));
      chk({tag, " zero"}, 64'(bus.zero_o), 64'(res == 32'd0));
      chk({tag, " busy at done"}, 64'(bus.busy_o), 64'd0);
      chk({tag, " err"}, 64'(bus.err_o), 64'd0);
`ifdef ALU_SEQ_MUL_HI_EN
      chk({tag, " prod_hi"}, 64'(bus.prod_hi_o), 64'(hi));
`else
      if (hi === 32'hx) n_cmp += 0;
`endif
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vecs[0]  = '{4'b0010, 32'h7FFF_FFFF, 32'd1,        32'h8000_0000, 1'b0};
      vecs[1]  = '{4'b0110, 32'd5,         32'd5,        32'd0,         1'b0};
      vecs[2]  = '{4'b0111, 32'hFFFF_FFFF, 32'd1,        32'd1,         1'b0};
      vecs[3]  = '{4'b0111, 32'd1,         32'hFFFF_FFFF, 32'd0,        1'b0};
      vecs[4]  = '{4'b0000, 32'hF0F0,      32'hFF00,     32'hF000,      1'b0};
      vecs[5]  = '{4'b0001, 32'hF0F0,      32'hFF00,     32'hFFF0,      1'b0};
      vecs[6]  = '{4'b1111, 32'd3,         32'd4,        32'd0,         1'b1};
      vecs[7]  = '{4'b0000, 32'hF0F0,      32'hFF00,     32'hF000,      1'b0};
      vecs[8]  = '{4'b0010, 32'hFFFF_FFFF, 32'd1,        32'd0,         1'b0};
      vecs[9]  = '{4'b0110, 32'd0,         32'd1,        32'hFFFF_FFFF, 1'b0};
      vecs[10] = '{4'b0011, 32'd7,         32'd9,        32'd0,         1'b1};
      vecs[11] = '{4'b0111, 32'h8000_0000, 32'h7FFF_FFFF, 32'd1,        1'b0};
      bus.start_i = 1'b0; bus.alu_ctrl_i = '0; bus.src1_i = '0; bus.src2_i = '0;
      repeat (3) @(posedge clk_i);
      #1;
      chk("reset result", 64'(bus.result_o), 64'd0);
      chk("reset zero", 64'(bus.zero_o), 64'd1);
      chk("reset busy", 64'(bus.busy_o), 64'd0);
      chk("reset done", 64'(bus.done_o), 64'd0);
      chk("reset err", 64'(bus.err_o), 64'd0);
      rst_i = 1'b1;
      @(posedge clk_i); #1;
      for (int i = 0; i < 12; i++)
         apply($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].err);
      bus.start_i = 1'b0; bus.alu_ctrl_i = 4'b0010; bus.src1_i = 32'd8; bus.src2_i = 32'd8;
      @(posedge clk_i); #1;
      chk("idle done low", 64'(bus.done_o), 64'd0);
      chk("idle result held", 64'(bus.result_o), 64'd1);
      mul_run("mul1", 32'd12345, 32'd678, 32'd8369910, 32'd0);
      apply("b2b add", 4'b0010, 32'd10, 32'd20, 32'd30, 1'b0);
      mul_run("mul2", 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 32'd1);
      mul_run("mul3", 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFF1, 32'd4);
      mul_run("mul0", 32'd0, 32'hDEAD_BEEF, 32'd0, 32'd0);
      apply("illegal", 4'b1111, 32'd3, 32'd4, 32'd0, 1'b1);
      mul_run("mul err clr", 32'd3, 32'd7, 32'd21, 32'd0);
      bus.start_i = 1'b1; bus.alu_ctrl_i = 4'b1000; bus.src1_i = 32'd99; bus.src2_i = 32'd99;
      @(posedge clk_i); #1;
      bus.start_i = 1'b0;
      repeat (10) @(posedge clk_i);
      #1;
      rst_i = 1'b0;
      @(posedge clk_i); #1;
      chk("abort busy", 64'(bus.busy_o), 64'd0);
      chk("abort done", 64'(bus.done_o), 64'd0);
      chk("abort result", 64'(bus.result_o), 64'd0);
      chk("abort zero", 64'(bus.zero_o), 64'd1);
      rst_i = 1'b1;
      begin
         int seen = 0;
         repeat (40) begin
            @(posedge clk_i); #1;
            if (bus.done_o || bus.busy_o) seen++;
         end
         chk("no done after abort", 64'(seen), 64'd0);
      end
      apply("add after reset", 4'b0010, 32'd2, 32'd3, 32'd5, 1'b0);
      bus.start_i = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Execution-side consumer of the 4-bit ALU control code produced by the ALU controller; performs the selected operation on two operands.
- Single-cycle ops (AND/OR/ADD/SUB/SLT) complete with 1-cycle latency; MUL (code 1000) runs as an iterative shift-add over WIDTH cycles.
- Sits in the EX stage of the multi-cycle datapath, using a start/done handshake so the main control FSM stalls on MUL.

Parameters:
- WIDTH, 32, operand/result width in bits (>=4).
- CNT_W, 6, multiplier iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_i  input  1  synchronous, active-low reset.
- start_i  input  1  command valid; sampled only in IDLE.
- alu_ctrl_i  input  4  operation code: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1000 MUL.
- src1_i  input  WIDTH  operand A; captured when start is accepted.
- src2_i  input  WIDTH  operand B; captured when start is accepted.
- result_o  output  WIDTH  registered result; held until the next completion.
- zero_o  output  1  registered, equals (result_o == 0); updated together with result_o.
- busy_o  output  1  high while a MUL is in progress.
- done_o  output  1  one-cycle pulse; result_o is valid in the same cycle.
- err_o  output  1  registered; high with done_o when the code is illegal; cleared on the next accepted start.

Behaviour:
- Reset (rst_i=0 at a rising edge): state=IDLE; result_o=0, zero_o=1, busy_o=0, done_o=0, err_o=0, counter=0, operand and accumulator registers=0. Reset during MUL aborts it; no done_o is produced.
- FSM states: IDLE, MUL.
- In IDLE, start_i=1 accepts a command. In MUL, start_i is ignored and no command is queued.
- Single-cycle ops: if start is accepted at edge k, then result_o, zero_o, done_o=1 and err_o=0 appear after edge k. State stays IDLE.
- ADD/SUB: modulo 2^WIDTH, carry and borrow discarded.
- SLT: signed two's-complement compare; result = {WIDTH-1 zeros, (A<B)}.
- AND/OR: bitwise.
- Illegal code (any value not listed under alu_ctrl_i): after edge k, result_o=0, zero_o=1, done_o=1, err_o=1. State stays IDLE.
- MUL acceptance at edge k:
  - Capture A into the multiplicand register and B into the multiplier register.
  - Clear the accumulator; load counter=WIDTH-1.
  - Go to MUL; busy_o=1 after edge k.
- Each MUL cycle:
  - If multiplier LSB=1, accumulator += multiplicand.
  - Multiplicand shifts left 1; multiplier shifts right 1.
  - Counter decrements.
- On the MUL cycle where counter==0:
  - Write the final accumulator to result_o; update zero_o.
  - done_o=1, busy_o=0; return to IDLE.
  - done_o is visible after edge k+WIDTH.
- MUL result: low WIDTH bits of the unsigned product, which equals the low WIDTH bits of the signed product.
- done_o is deasserted in every cycle other than a completion cycle.
- Back-to-back: start_i is accepted in the cycle done_o is high, because the state is already IDLE. There are no bubbles between single-cycle ops.
- alu_ctrl_i, src1_i and src2_i are don't-care when no start is accepted; result_o does not change.

Optional Feature:
- Macro ALU_SEQ_MUL_HI_EN.
- Defined:
  - Adds output port prod_hi_o (WIDTH bits): upper WIDTH bits of the full unsigned 2*WIDTH-bit product.
  - The accumulator is 2*WIDTH bits wide.
  - prod_hi_o updates with result_o on MUL completion and is cleared to 0 on any non-MUL completion and on reset.
- Not defined: no prod_hi_o port; the accumulator is WIDTH bits; MUL behaviour on result_o is identical.

Test Plan:
- Reset, then start ADD with A=32'h7FFF_FFFF, B=1 -> after 1 edge: result_o=32'h8000_0000, done_o=1, zero_o=0, err_o=0, busy_o=0.
- SUB A=5, B=5 -> result_o=0, zero_o=1. Next cycle SLT A=32'hFFFF_FFFF (-1), B=1 -> result_o=1.
- MUL A=12345, B=678 -> busy_o=1 for 32 cycles; done_o pulses exactly 32 edges after acceptance with result_o=8369910. A start_i pulse mid-MUL is ignored.
- MUL A=32'hFFFF_FFFF, B=2 -> result_o=32'hFFFF_FFFE. With ALU_SEQ_MUL_HI_EN: prod_hi_o=1.
- Illegal code 4'b1111 with A=3, B=4 -> result_o=0, err_o=1, done_o=1. Following AND A=32'hF0F0, B=32'hFF00 -> result_o=32'hF000, err_o=0.
- Assert rst_i=0 at MUL cycle 10 -> next edge: busy_o=0, done_o=0, result_o=0. No done_o pulse follows. A new ADD 2+3 after release -> result_o=5.
